// File: rtl/mul_pkg.sv
// Shared multiplier-datapath definitions: FSM states, kpg carry codes and row-width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Carry codes understood by the kpg/ppc final adder
  localparam logic [7:0] KPG_K = 8'h6B;
  localparam logic [7:0] KPG_P = 8'h70;
  localparam logic [7:0] KPG_G = 8'h67;

  localparam int unsigned N_DEF = 16;

  function automatic int unsigned row_width(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational 3:2 compressor row: s = x^y^z, c = maj(x,y,z) shifted left by one (truncated).
module csa_row #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-1:0] maj;

  assign maj = (x & y) | (x & z) | (y & z);
  assign s   = x ^ y ^ z;
  assign c   = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_pp_accumulator.sv
// Iterative carry-save partial-product accumulator; hands a redundant sum/carry row pair
// to the final kpg carry-lookahead adder.
module csa_pp_accumulator
  import mul_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter bit          EARLY_TERM = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] sum_row,
  output logic [2*N-1:0] carry_row,
  output logic [7:0]     cin_kpg,
  output logic           busy
);

  localparam int unsigned W  = row_width(N);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [W-1:0]   mcand_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   pp_c, sum_c, carry_c;
  logic [N-1:0]   mplier_shr_c;
  logic           last_step_c;
  logic           accept_c;

  assign pp_c         = mplier_q[0] ? mcand_q : '0;
  assign mplier_shr_c = mplier_q >> 1;
  assign last_step_c  = (cnt_q == CW'(N - 1)) || (EARLY_TERM && (mplier_shr_c == '0));
  assign cin_kpg      = KPG_K;

  csa_row #(.W(W)) u_csa_row (
    .x (sum_row),
    .y (carry_row),
    .z (pp_c),
    .s (sum_c),
    .c (carry_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = ACCUM;
          accept_c = 1'b1;
        end
      end
      ACCUM: begin
        if (last_step_c) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand load on accept, one shift-and-compress step per ACCUM cycle, rows frozen otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      sum_row   <= '0;
      carry_row <= '0;
    end else if (accept_c) begin
      mcand_q   <= W'(in_a);
      mplier_q  <= in_b;
      cnt_q     <= '0;
      sum_row   <= '0;
      carry_row <= '0;
    end else if (state_q == ACCUM) begin
      mcand_q   <= mcand_q << 1;
      mplier_q  <= mplier_shr_c;
      cnt_q     <= cnt_q + CW'(1);
      sum_row   <= sum_c;
      carry_row <= carry_c;
    end
  end

endmodule

// File: tb/tb_csa_pp_accumulator.sv
// Bench for csa_pp_accumulator: one instance per EARLY_TERM value against a transaction-level model.
module tb_csa_pp_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [2];
  logic        out_ready [2];
  logic [15:0] in_a      [2];
  logic [15:0] in_b      [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [31:0] sum_row   [2];
  logic [31:0] carry_row [2];
  logic [7:0]  cin_kpg   [2];

  int tests = 0;
  int fails = 0;

  csa_pp_accumulator #(.N(16), .EARLY_TERM(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum_row(sum_row[0]), .carry_row(carry_row[0]), .cin_kpg(cin_kpg[0]), .busy(busy[0])
  );

  csa_pp_accumulator #(.N(16), .EARLY_TERM(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum_row(sum_row[1]), .carry_row(carry_row[1]), .cin_kpg(cin_kpg[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d] @%0t: got %h expected %h", name, s, $time, act, exp);
    end
  endtask

  // Expected latency: full N steps, or up to the multiplier's top set bit with early termination
  function automatic int exp_lat(input int s, input logic [15:0] b);
    if (s == 0) return 16;
    for (int i = 15; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  // Transaction model: an accepted op is busy for k edges, then offers its product until taken
  bit          model_on = 1'b0;
  bit          busy_m [2];
  int          age_m  [2];
  int          k_m    [2];
  logic [31:0] prod_m [2];

  always @(posedge clk) begin
    if (!rst_n) begin
      model_on = 1'b1;
      for (int s = 0; s < 2; s++) busy_m[s] = 1'b0;
    end else if (model_on) begin
      for (int s = 0; s < 2; s++) begin
        if (!busy_m[s]) begin
          if (in_valid[s]) begin
            busy_m[s] = 1'b1;
            age_m[s]  = 0;
            k_m[s]    = exp_lat(s, in_b[s]);
            prod_m[s] = 32'(in_a[s]) * 32'(in_b[s]);
          end
        end else if (age_m[s] >= k_m[s]) begin
          if (out_ready[s]) busy_m[s] = 1'b0;
        end else begin
          age_m[s]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int s = 0; s < 2; s++) begin
        logic ov_m;
        ov_m = busy_m[s] && (age_m[s] >= k_m[s]);
        chk("in_ready", s, 32'(in_ready[s]), 32'(!busy_m[s]));
        chk("busy", s, 32'(busy[s]), 32'(busy_m[s]));
        chk("out_valid", s, 32'(out_valid[s]), 32'(ov_m));
        chk("cin_kpg", s, 32'(cin_kpg[s]), 32'h6B);
        if (ov_m) chk("product", s, sum_row[s] + carry_row[s], prod_m[s]);
      end
    end
  end

  // One operation: accept, wait for rows, optionally stall in DONE while poking in_valid
  task automatic do_op(input int s, input logic [15:0] a, input logic [15:0] b, input int hold,
                       output int lat, output logic [31:0] res);
    int guard;
    logic [31:0] s0, c0;
    guard = 0;
    while (!in_ready[s] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("accept_timeout", s, 32'(guard >= 100), 32'd0);
    in_a[s] = a; in_b[s] = b; in_valid[s] = 1'b1; out_ready[s] = (hold == 0);
    @(posedge clk); #1;
    in_valid[s] = 1'b0; in_a[s] = 16'($urandom); in_b[s] = 16'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid[s] && lat < 100);
    chk("done_timeout", s, 32'(out_valid[s]), 32'd1);
    res = sum_row[s] + carry_row[s];
    s0 = sum_row[s]; c0 = carry_row[s];
    for (int i = 0; i < hold; i++) begin
      in_valid[s] = 1'b1; in_a[s] = 16'($urandom); in_b[s] = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_sum", s, sum_row[s], s0);
      chk("hold_carry", s, carry_row[s], c0);
      chk("hold_in_ready", s, 32'(in_ready[s]), 32'd0);
    end
    in_valid[s] = 1'b0; out_ready[s] = 1'b1;
    @(posedge clk); #1;
    out_ready[s] = 1'b0;
    chk("drop_valid", s, 32'(out_valid[s]), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] res;
    logic [15:0] a, b;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; out_ready[s] = 1'b0; in_a[s] = '0; in_b[s] = '0;
    end

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_sum", s, sum_row[s], 32'd0);
      chk("rst_carry", s, carry_row[s], 32'd0);
      chk("rst_in_ready", s, 32'(in_ready[s]), 32'd1);
    end
    rst_n = 1'b1;

    // Full-width operands on both variants
    for (int s = 0; s < 2; s++) begin
      do_op(s, 16'hFFFF, 16'hFFFF, 0, lat, res);
      chk("ffff_lat", s, 32'(lat), 32'd16);
      chk("ffff_res", s, res, 32'hFFFE0001);
    end

    // Zero multiplier and small operands
    do_op(1, 16'h1234, 16'h0000, 0, lat, res);
    chk("b0_lat", 1, 32'(lat), 32'd1);
    chk("b0_res", 1, res, 32'd0);
    do_op(0, 16'h1234, 16'h0000, 0, lat, res);
    chk("b0_lat", 0, 32'(lat), 32'd16);
    chk("b0_res", 0, res, 32'd0);
    do_op(1, 16'd3, 16'd5, 0, lat, res);
    chk("3x5_lat", 1, 32'(lat), 32'd3);
    chk("3x5_res", 1, res, 32'd15);
    do_op(1, 16'h8000, 16'h8000, 1, lat, res);
    chk("msb_lat", 1, 32'(lat), 32'd16);
    chk("msb_res", 1, res, 32'h40000000);

    // Backpressure for five cycles, then a fresh op
    do_op(1, 16'd3, 16'd5, 5, lat, res);
    chk("bp_res", 1, res, 32'd15);
    do_op(1, 16'd100, 16'd200, 0, lat, res);
    chk("after_bp_res", 1, res, 32'd20000);
    chk("after_bp_lat", 1, 32'(lat), 32'd8);

    // Reset landing on the fourth accumulate step
    @(posedge clk); #1;
    in_a[1] = 16'hABCD; in_b[1] = 16'hABCD; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 1, 32'(in_ready[1]), 32'd1);
    repeat (20) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 1, 32'(out_valid[1]), 32'd0);
    end
    out_ready[1] = 1'b0;
    do_op(1, 16'd7, 16'd9, 0, lat, res);
    chk("7x9_lat", 1, 32'(lat), 32'd4);
    chk("7x9_res", 1, res, 32'd63);

    // Random operands, idle gaps and stalls on both variants
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        a = 16'($urandom);
        case ($urandom_range(0, 3))
          0: b = 16'($urandom_range(0, 15));
          1: b = 16'($urandom) >> $urandom_range(0, 15);
          default: b = 16'($urandom);
        endcase
        do_op(s, a, b, int'($urandom_range(0, 3)), lat, res);
        chk("rand_lat", s, 32'(lat), 32'(exp_lat(s, b)));
        chk("rand_res", s, res, 32'(a) * 32'(b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
